// File: rtl/special_step_arbiter_if.sv
// Handshake bundle between the step controllers, the arbiter and the shared
// special_step compute unit.
interface special_step_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      ack_data;
  logic               timeout_err;
  logic               busy;
  logic [2:0]         grant_id;
  logic               unit_enable;
  logic               unit_start;
  logic [DW-1:0]      unit_data_in;
  logic [DW-1:0]      unit_data_out;
  logic               unit_done;

  modport slave (
    input  req, req_data, unit_data_out, unit_done,
    output ack, ack_data, timeout_err, busy, grant_id,
           unit_enable, unit_start, unit_data_in
  );

  modport master (
    output req, req_data, unit_data_out, unit_done,
    input  ack, ack_data, timeout_err, busy, grant_id,
           unit_enable, unit_start, unit_data_in
  );
endinterface

// File: rtl/special_step_arbiter.sv
// Round-robin arbiter sharing one clock-gated special_step unit between NREQ
// step controllers, with a clock-off isolation cycle between grants.
module special_step_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  special_step_arbiter_if.slave  io_arb
);

  typedef enum logic [2:0] {IDLE, GATE_ON, RUN, RESP, COOL} state_t;

  localparam logic [7:0]      MAXW    = 8'(MAX_WAIT);
  localparam logic [2:0]      LAST_ID = 3'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [2:0]      r_ptr;
  logic [2:0]      r_grant;
  logic [7:0]      r_cnt;
  logic [DW-1:0]   r_op;
  logic [DW-1:0]   r_result;
  logic [NREQ-1:0] r_ack;
  logic            r_timeout_err;
  logic            r_busy;
  logic            r_enable;
  logic            r_start;
  logic [2:0]      w_winner;

  // First requester at or above ptr, wrapping; lower offsets overwrite higher ones.
  function automatic logic [2:0] f_pick(input logic [NREQ-1:0] req, input logic [2:0] ptr);
    int j;
    f_pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (req[j]) f_pick = 3'(j);
    end
  endfunction

  assign w_winner = f_pick(io_arb.req, r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_cnt         <= '0;
      r_op          <= '0;
      r_result      <= '0;
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
      r_enable      <= 1'b0;
      r_start       <= 1'b0;
    end else begin
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|io_arb.req) begin
            r_state  <= GATE_ON;
            r_grant  <= w_winner;
            r_op     <= io_arb.req_data[w_winner*DW +: DW];
            r_ptr    <= (w_winner == LAST_ID) ? 3'd0 : w_winner + 3'd1;
            r_enable <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        // Gate enabled one full cycle before start so the unit clock is stable.
        GATE_ON: begin
          r_state <= RUN;
          r_start <= 1'b1;
          r_cnt   <= 8'd1;
        end
        RUN: begin
          if (io_arb.unit_done) begin
            r_state  <= RESP;
            r_start  <= 1'b0;
            r_result <= io_arb.unit_data_out;
            r_ack    <= ONE_HOT << r_grant;
          end else if (r_cnt == MAXW) begin
            r_state       <= RESP;
            r_start       <= 1'b0;
            r_result      <= '0;
            r_ack         <= ONE_HOT << r_grant;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_state  <= COOL;
          r_enable <= 1'b0;
        end
        COOL: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_arb.ack          = r_ack;
  assign io_arb.ack_data     = (|r_ack) ? r_result : '0;
  assign io_arb.timeout_err  = r_timeout_err;
  assign io_arb.busy         = r_busy;
  assign io_arb.grant_id     = r_grant;
  assign io_arb.unit_enable  = r_enable;
  assign io_arb.unit_start   = r_start;
  assign io_arb.unit_data_in = r_op;

endmodule

// File: tb/tb_special_step_arbiter.sv
// Directed bench for special_step_arbiter: transaction-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_special_step_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  special_step_arbiter_if #(.NREQ(NREQ), .DW(DW)) arb_if ();

  special_step_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_arb(arb_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Compute-unit stand-in: done k cycles after start rises, result = ~operand.
  logic          rsp_en = 1'b1;
  int            rsp_k = 3;
  int            scnt = 0;
  logic          rsp_done = 1'b0;
  logic          stray = 1'b0;
  logic [DW-1:0] rsp_val = 8'h5A;
  assign arb_if.unit_done     = rsp_done | stray;
  assign arb_if.unit_data_out = rsp_val;

  always @(negedge clk) begin
    if (arb_if.unit_start) begin
      rsp_done = rsp_en && (scnt == rsp_k);
      rsp_val  = rsp_done ? ~arb_if.unit_data_in : 8'h5A;
      scnt++;
    end else begin
      scnt     = 0;
      rsp_done = 1'b0;
      rsp_val  = 8'h5A;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one transaction at a time, described by its grant cycle and ack cycle.
  bit            m_act = 0;
  int            m_g = 0;
  int            m_tack = -1;
  int            m_ptr = 0;
  int            m_id = 0;
  logic [DW-1:0] m_op = '0;
  logic [DW-1:0] m_res = '0;
  logic          m_to = 1'b0;

  always @(posedge clk) begin
    bit found;
    if (!rst_n) begin
      m_act = 0; m_ptr = 0; m_id = 0; m_op = '0; m_tack = -1;
    end else if (m_act) begin
      if (m_tack < 0) begin
        if (cyc >= m_g + 2) begin
          if (arb_if.unit_done) begin
            m_tack = cyc + 1; m_res = arb_if.unit_data_out; m_to = 1'b0;
          end else if (cyc == m_g + 1 + MW) begin
            m_tack = cyc + 1; m_res = '0; m_to = 1'b1;
          end
        end
      end else if (cyc == m_tack + 1) begin
        m_act = 0;
      end
    end else if (arb_if.req != '0) begin
      found = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && arb_if.req[(m_ptr + i) % NREQ]) begin
          m_id = (m_ptr + i) % NREQ;
          found = 1;
        end
      end
      m_op   = arb_if.req_data[m_id*DW +: DW];
      m_ptr  = (m_id + 1) % NREQ;
      m_g    = cyc;
      m_tack = -1;
      m_act  = 1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] e_ack;
    logic            e_busy, e_en, e_st;
    if (!rst_n) begin
      e_ack = '0; e_busy = 0; e_en = 0; e_st = 0;
    end else begin
      e_busy = m_act && (cyc >= m_g + 1);
      e_en   = e_busy && (m_tack < 0 || cyc <= m_tack);
      e_st   = m_act && (cyc >= m_g + 2) && (m_tack < 0);
      e_ack  = (m_act && cyc == m_tack) ? (NREQ'(1) << m_id) : '0;
    end
    chk("ack", 32'(arb_if.ack), 32'(e_ack));
    chk("ack_data", 32'(arb_if.ack_data), (e_ack != '0) ? 32'(m_res) : 32'h0);
    chk("timeout_err", 32'(arb_if.timeout_err), (e_ack != '0) ? 32'(m_to) : 32'h0);
    chk("busy", 32'(arb_if.busy), 32'(e_busy));
    chk("unit_enable", 32'(arb_if.unit_enable), 32'(e_en));
    chk("unit_start", 32'(arb_if.unit_start), 32'(e_st));
    chk("grant_id", 32'(arb_if.grant_id), rst_n ? 32'(m_id) : 32'h0);
    chk("unit_data_in", 32'(arb_if.unit_data_in), rst_n ? 32'(m_op) : 32'h0);
  end

  // Event log used by the literal expectations.
  int            a_cyc[$];
  int            a_id[$];
  logic [DW-1:0] a_dat[$];
  logic          a_to[$];
  int            s_rise[$];
  int            b_fall = -1;
  logic          prev_busy = 1'b0;
  logic          prev_start = 1'b0;

  always @(negedge clk) begin
    int id;
    if (rst_n) begin
      if (arb_if.ack != '0) begin
        id = 0;
        for (int i = 0; i < NREQ; i++) if (arb_if.ack[i]) id = i;
        a_cyc.push_back(cyc);
        a_id.push_back(id);
        a_dat.push_back(arb_if.ack_data);
        a_to.push_back(arb_if.timeout_err);
      end
      if (arb_if.unit_start && !prev_start) s_rise.push_back(cyc);
      if (prev_busy && !arb_if.busy) b_fall = cyc;
    end
    prev_busy  = arb_if.busy;
    prev_start = arb_if.unit_start;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Wait for n acks; optionally each served requester drops its request on its ack.
  task automatic serve(input int n, input bit drop);
    int base;
    int guard;
    base = a_id.size();
    guard = 0;
    while (a_id.size() < base + n && guard < 200) begin
      tick();
      guard++;
      if (drop && a_id.size() > 0 && a_cyc[$] == cyc) arb_if.req[a_id[$]] = 1'b0;
    end
    chk("ack_count", 32'(a_id.size() - base), 32'(n));
  endtask

  logic [DW-1:0] t2d [4] = '{8'hEF, 8'hDF, 8'hCF, 8'hBF};
  int t3id [3] = '{3, 1, 2};
  logic [DW-1:0] t3d [3] = '{8'hBF, 8'hDF, 8'hCF};
  int t5id [3] = '{0, 2, 3};

  initial begin
    int t0;
    int ab;
    arb_if.req = '0;
    arb_if.req_data = '0;
    tick(); tick();
    chk("rst_busy", 32'(arb_if.busy), 0);
    chk("rst_enable", 32'(arb_if.unit_enable), 0);
    chk("rst_ack", 32'(arb_if.ack), 0);
    rst_n = 1'b1;
    tick();

    // Single request, k=3.
    arb_if.req_data = {8'h40, 8'h30, 8'h20, 8'h12};
    arb_if.req = 4'b0001;
    t0 = cyc;
    serve(1, 1);
    repeat (4) tick();
    if (a_id.size() >= 1 && s_rise.size() >= 1) begin
      chk("t1_ack_cycle", 32'(a_cyc[0] - t0), 6);
      chk("t1_ack_data", 32'(a_dat[0]), 32'hED);
      chk("t1_ack_id", 32'(a_id[0]), 0);
      chk("t1_start_rise", 32'(s_rise[0] - t0), 2);
    end
    chk("t1_busy_fall", 32'(b_fall - t0), 8);

    // All four held from ptr=0.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    ab = a_id.size();
    arb_if.req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    arb_if.req = 4'b1111;
    serve(5, 0);
    arb_if.req = '0;
    repeat (4) tick();
    if (a_id.size() >= ab + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("t2_id", 32'(a_id[ab+i]), 32'(i % 4));
        chk("t2_data", 32'(a_dat[ab+i]), 32'(t2d[i % 4]));
      end
      chk("t2_spacing", 32'(a_cyc[ab+4] - a_cyc[ab+3]), 8);
    end

    // req[3], then req[1] and req[2] during its service; operand change ignored.
    ab = a_id.size();
    arb_if.req = 4'b1000;
    tick(); tick();
    arb_if.req[1] = 1'b1;
    arb_if.req_data[31:24] = 8'h77;
    tick();
    arb_if.req[2] = 1'b1;
    serve(3, 1);
    repeat (4) tick();
    if (a_id.size() >= ab + 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t3_id", 32'(a_id[ab+i]), 32'(t3id[i]));
        chk("t3_data", 32'(a_dat[ab+i]), 32'(t3d[i]));
      end
    end
    arb_if.req_data[31:24] = 8'h40;

    // Timeout, then done exactly at the last allowed RUN cycle.
    ab = a_id.size();
    rsp_en = 1'b0;
    arb_if.req = 4'b0010;
    t0 = cyc;
    serve(1, 1);
    rsp_en = 1'b1;
    if (a_id.size() >= ab + 1) begin
      chk("t4_to_cycle", 32'(a_cyc[ab] - t0), 32'(2 + MW));
      chk("t4_to_data", 32'(a_dat[ab]), 0);
      chk("t4_to_flag", 32'(a_to[ab]), 1);
    end
    repeat (2) tick();
    rsp_k = MW - 1;
    arb_if.req = 4'b0100;
    t0 = cyc;
    serve(1, 1);
    rsp_k = 3;
    if (a_id.size() >= ab + 2) begin
      chk("t4_edge_cycle", 32'(a_cyc[ab+1] - t0), 32'(2 + MW));
      chk("t4_edge_data", 32'(a_dat[ab+1]), 32'hCF);
      chk("t4_edge_flag", 32'(a_to[ab+1]), 0);
    end
    repeat (4) tick();

    // Reset during RUN.
    ab = a_id.size();
    rsp_en = 1'b0;
    arb_if.req = 4'b0100;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_enable", 32'(arb_if.unit_enable), 0);
    chk("t5_start", 32'(arb_if.unit_start), 0);
    chk("t5_busy", 32'(arb_if.busy), 0);
    chk("t5_grant", 32'(arb_if.grant_id), 0);
    arb_if.req = '0;
    tick(); tick();
    rst_n = 1'b1;
    rsp_en = 1'b1;
    tick();
    chk("t5_no_ack", 32'(a_id.size() - ab), 0);
    arb_if.req = 4'b1101;
    serve(3, 1);
    repeat (4) tick();
    if (a_id.size() >= ab + 3)
      for (int i = 0; i < 3; i++) chk("t5_id", 32'(a_id[ab+i]), 32'(t5id[i]));

    // Stray done in IDLE and COOL.
    ab = a_id.size();
    stray = 1'b1; tick(); stray = 1'b0; tick();
    chk("t6_idle_busy", 32'(arb_if.busy), 0);
    arb_if.req = 4'b0001;
    serve(1, 1);
    tick();
    stray = 1'b1; tick(); tick();
    stray = 1'b0;
    repeat (3) tick();
    chk("t6_acks", 32'(a_id.size() - ab), 1);
    chk("t6_busy", 32'(arb_if.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
